// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, cycle counts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    // op[1] selects divide; op[0] selects unsigned
    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULU = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_DIVU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Number of MUL-state cycles needed to retire every multiplier bit
    function automatic int mul_cycles(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_in/bit_in = partial remainder and next dividend bit, divisor = |divisor|,
//        rem_out = new partial remainder, q_bit = quotient bit produced by this step.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so shifted < 2*divisor and the top bit of
    // the (WIDTH+1)-bit difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply (MUL_STEP bits/cycle) and restoring divide (1 bit/cycle) for EX.
// Latency: MUL WIDTH/MUL_STEP+1, DIV WIDTH+1, divide-by-zero 2 cycles from accepted start to done.
// Backpressure: start is only sampled in IDLE; caller holds start/stall while busy. annul aborts MUL/DIV.
// Ports: start/op/src_a/src_b request, annul abort, busy/done status,
//        hi/lo result (product halves or remainder/quotient), div_by_zero flag valid with done.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int MUL_CYCLES = mul_cycles(WIDTH, MUL_STEP);
    localparam int CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    md_state_e            state;
    logic [2*WIDTH-1:0]   a_reg;     // multiplicand, shifted left each MUL cycle
    logic [WIDTH-1:0]     b_reg;     // multiplier (shifted right) or divisor
    logic [2*WIDTH-1:0]   acc;       // MUL: product; DIV: {remainder, dividend/quotient}
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_a;
    logic                 neg_b;
    logic                 dbz;

    logic                 in_signed;
    logic                 in_sa;
    logic                 in_sb;
    logic                 in_dbz;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_q;

    // Operand conditioning at accept time. Negating MIN yields MIN, which is
    // exactly 2^(WIDTH-1) read as unsigned, so no special case is needed.
    always_comb begin
        in_signed = ~op[0];
        in_sa     = in_signed & src_a[WIDTH-1];
        in_sb     = in_signed & src_b[WIDTH-1];
        a_abs     = in_sa ? -src_a : src_a;
        b_abs     = in_sb ? -src_b : src_b;
        in_dbz    = op[1] & (src_b == '0);
    end

    // Partial products for the low MUL_STEP multiplier bits
    always_comb begin
        mul_sum = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (b_reg[i]) begin
                mul_sum = mul_sum + (a_reg << i);
            end
        end
    end

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .bit_in  (acc[WIDTH-1]),
        .divisor (b_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Next accumulator; a zero-divisor DIV keeps the raw {src_a, all-ones} pair
    always_comb begin
        acc_nxt = acc;
        case (state)
            ST_MUL:  acc_nxt = mul_sum;
            ST_DIV:  acc_nxt = dbz ? acc : {step_rem, acc[WIDTH-2:0], step_q};
            default: acc_nxt = acc;
        endcase
    end

    // Sign fixup, computed from the final accumulator value
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
        if (is_div) begin
            if (dbz) begin
                res_hi = acc_nxt[2*WIDTH-1:WIDTH];
                res_lo = acc_nxt[WIDTH-1:0];
            end else begin
                res_hi = neg_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
                res_lo = (neg_a ^ neg_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
            end
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start && !annul) begin
                        is_div <= op[1];
                        neg_a  <= in_sa;
                        neg_b  <= in_sb;
                        dbz    <= in_dbz;
                        a_reg  <= {{WIDTH{1'b0}}, a_abs};
                        b_reg  <= b_abs;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (op[1]) begin
                            state <= ST_DIV;
                            acc   <= in_dbz ? {src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            state <= ST_MUL;
                            acc   <= '0;
                        end
                    end
                end
                ST_MUL: begin
                    if (annul) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= acc_nxt;
                        a_reg <= a_reg << MUL_STEP;
                        b_reg <= b_reg >> MUL_STEP;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == MUL_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            hi    <= res_hi;
                            lo    <= res_lo;
                        end
                    end
                end
                ST_DIV: begin
                    if (annul) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        // Zero divisor spends a single DIV cycle, giving done two cycles after accept
                        if (dbz || cnt == DIV_LAST) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            div_by_zero <= dbz;
                            hi          <= res_hi;
                            lo          <= res_lo;
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: vector table through a scoreboard plus
// hand-written annul / reset / held-start / multi-step-width sequences.
module tb_muldiv_iter_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        annul;

    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    logic        busy1, done1, dbz1;
    logic [31:0] hi1, lo1;
    logic        busy4, done4, dbz4;
    logic [31:0] hi4, lo4;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
    );
    muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_by_zero(dbz1)
    );
    muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4), .div_by_zero(dbz4)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   t_iss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any done pulse of the main DUT
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
                chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    endtask

    // Drive a one-cycle start at the current falling edge, then scramble inputs
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input string name, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz, input int elat);
        exp_t e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        t_iss = cyc;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = elat; e.t0 = cyc; e.name = name;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Wait (bounded) for done, then check it was a single-cycle pulse
    task automatic wait_done(input string name, input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < bound);
        chk({name, "_done_seen"}, {31'b0, done}, 32'd1);
        tick();
        chk({name, "_pulse"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        int lat1, lat4, n;
        logic [31:0] h1, l1, h4, l4;
        logic z1, z4;

        vecs[0]  = '{MD_MUL,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 17};
        vecs[1]  = '{MD_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 17};
        vecs[2]  = '{MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[4]  = '{MD_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 2};
        vecs[5]  = '{MD_MUL,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 17};
        vecs[6]  = '{MD_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[7]  = '{MD_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
        vecs[8]  = '{MD_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
        vecs[9]  = '{MD_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 17};
        vecs[10] = '{MD_MULU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 17};

        rst = 1'b1; start = 1'b0; annul = 1'b0; op = MD_MUL; src_a = '0; src_b = '0;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz",  {31'b0, dbz},  32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b0;
        tick();

        // Table vectors, issued back-to-back in the cycle after each done
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, $sformatf("v%0d", i),
                  vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd1);
            wait_done($sformatf("v%0d", i), 40);
        end

        // Same MULU on all three step widths
        n = 0;
        while ((busy1 | busy4 | busy) && n < 100) begin
            tick();
            n++;
        end
        chk("all_idle", {29'b0, busy1, busy4, busy}, 32'd0);
        lat1 = -1; lat4 = -1; h1 = '0; l1 = '0; h4 = '0; l4 = '0; z1 = 1'b1; z4 = 1'b1;
        issue(MD_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "w2", 32'hFFFFFFFE, 32'h00000001, 1'b0, 17);
        repeat (40) begin
            tick();
            if (done1 && lat1 < 0) begin lat1 = cyc - t_iss; h1 = hi1; l1 = lo1; z1 = dbz1; end
            if (done4 && lat4 < 0) begin lat4 = cyc - t_iss; h4 = hi4; l4 = lo4; z4 = dbz4; end
        end
        chk("w1_lat", 32'(lat1), 32'd33);
        chk("w1_hi", h1, 32'hFFFFFFFE);
        chk("w1_lo", l1, 32'h00000001);
        chk("w1_dbz", {31'b0, z1}, 32'd0);
        chk("w4_lat", 32'(lat4), 32'd9);
        chk("w4_hi", h4, 32'hFFFFFFFE);
        chk("w4_lo", l4, 32'h00000001);
        chk("w4_dbz", {31'b0, z4}, 32'd0);

        // DIV annulled at t+5; MULU 3x4 started at t+6
        issue(MD_DIV, 32'h00001234, 32'h00000011, 1'b0, "", '0, '0, 1'b0, 0);
        repeat (4) tick();
        chk("annul_busy_before", {31'b0, busy}, 32'd1);
        annul = 1'b1;
        tick();
        annul = 1'b0;
        chk("annul_busy_after", {31'b0, busy}, 32'd0);
        chk("annul_hi_kept", hi, 32'hFFFFFFFE);
        chk("annul_lo_kept", lo, 32'h00000001);
        issue(MD_MULU, 32'd3, 32'd4, 1'b1, "post_annul", 32'd0, 32'h0000000C, 1'b0, 17);
        wait_done("post_annul", 40);

        // start held through busy with different operands is ignored
        issue(MD_MUL, 32'd6, 32'd7, 1'b1, "held", 32'd0, 32'd42, 1'b0, 17);
        start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd3;
        repeat (10) tick();
        start = 1'b0;
        wait_done("held", 40);

        // Reset at t+10 of a DIV: everything cleared, no done
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, "", '0, '0, 1'b0, 0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_dbz",  {31'b0, dbz},  32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        rst = 1'b0;
        repeat (40) tick();

        // start & annul together in IDLE: request dropped
        start = 1'b1; annul = 1'b1; op = MD_MULU; src_a = 32'd5; src_b = 32'd5;
        tick();
        start = 1'b0; annul = 1'b0;
        chk("start_annul_idle", {31'b0, busy}, 32'd0);
        repeat (20) tick();
        chk("start_annul_lo", lo, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
